// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: owns HI/LO, runs one mult/div at a time for a
// fixed latency and commits at the end; also serves mfhi/mflo/mthi/mtlo.
module e_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  MDUOp,
    input  logic        Start,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Req,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] Out
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t         state_r;
    state_t         state_nxt_s;
    logic [CW-1:0]  cnt_r;
    logic [31:0]    phi_r;
    logic [31:0]    plo_r;
    logic           dz_r;
    logic [31:0]    hi_r;
    logic [31:0]    lo_r;

    logic           op_mul_s;
    logic           op_div_s;
    logic           accept_s;
    logic           mthi_s;
    logic           mtlo_s;
    logic           done_s;
    logic           commit_s;
    logic [31:0]    out_s;

    logic [63:0]    prod_s_s;
    logic [63:0]    prod_u_s;
    logic [31:0]    a_mag_s;
    logic [31:0]    b_mag_s;
    logic [31:0]    b_safe_s;
    logic [31:0]    qs_mag_s;
    logic [31:0]    rs_mag_s;
    logic [31:0]    qu_s;
    logic [31:0]    ru_s;
    logic [31:0]    res_hi_s;
    logic [31:0]    res_lo_s;
    logic           div_zero_s;

    assign op_mul_s   = (MDUOp == 4'd1) || (MDUOp == 4'd2);
    assign op_div_s   = (MDUOp == 4'd3) || (MDUOp == 4'd4);
    assign accept_s   = (state_r == IDLE) && Start && !Req && (op_mul_s || op_div_s);
    assign mthi_s     = (state_r == IDLE) && !Req && (MDUOp == 4'd7);
    assign mtlo_s     = (state_r == IDLE) && !Req && (MDUOp == 4'd8);
    assign done_s     = (state_r == RUN) && (cnt_r == CW'(1));
    assign div_zero_s = op_div_s && (B == 32'd0);

    // Arithmetic: signed divide done on magnitudes so that -2^31 / -1 never overflows.
    always_comb begin
        prod_s_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
        prod_u_s = {32'd0, A} * {32'd0, B};
        a_mag_s  = A[31] ? (32'd0 - A) : A;
        b_mag_s  = B[31] ? (32'd0 - B) : B;
        b_safe_s = (B == 32'd0) ? 32'd1 : B;
        if (b_mag_s == 32'd0) begin
            qs_mag_s = 32'd0;
            rs_mag_s = 32'd0;
        end else begin
            qs_mag_s = a_mag_s / b_mag_s;
            rs_mag_s = a_mag_s % b_mag_s;
        end
        qu_s = A / b_safe_s;
        ru_s = A % b_safe_s;
    end

    // Result selection for the pending HI/LO registers.
    always_comb begin
        res_hi_s = 32'd0;
        res_lo_s = 32'd0;
        case (MDUOp)
            4'd1: begin
                res_hi_s = prod_s_s[63:32];
                res_lo_s = prod_s_s[31:0];
            end
            4'd2: begin
                res_hi_s = prod_u_s[63:32];
                res_lo_s = prod_u_s[31:0];
            end
            4'd3: begin
                res_lo_s = (A[31] ^ B[31]) ? (32'd0 - qs_mag_s) : qs_mag_s;
                res_hi_s = A[31] ? (32'd0 - rs_mag_s) : rs_mag_s;
            end
            4'd4: begin
                res_lo_s = qu_s;
                res_hi_s = ru_s;
            end
            default: begin
                res_hi_s = 32'd0;
                res_lo_s = 32'd0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE:    state_nxt_s = accept_s ? RUN : IDLE;
            RUN:     state_nxt_s = done_s ? IDLE : RUN;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Output decode: commit strobe and read mux.
    always_comb begin
        commit_s = done_s && !dz_r;
        case (MDUOp)
            4'd5:    out_s = hi_r;
            4'd6:    out_s = lo_r;
            default: out_s = 32'd0;
        endcase
    end

    // Counter, pending results and architectural HI/LO.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r <= {CW{1'b0}};
            phi_r <= 32'd0;
            plo_r <= 32'd0;
            dz_r  <= 1'b0;
            hi_r  <= 32'd0;
            lo_r  <= 32'd0;
        end else begin
            if (accept_s) begin
                cnt_r <= op_mul_s ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
                phi_r <= res_hi_s;
                plo_r <= res_lo_s;
                dz_r  <= div_zero_s;
            end else if (state_r == RUN) begin
                cnt_r <= cnt_r - CW'(1);
            end else begin
                cnt_r <= cnt_r;
            end

            if (commit_s) begin
                hi_r <= phi_r;
            end else if (mthi_s) begin
                hi_r <= A;
            end else begin
                hi_r <= hi_r;
            end

            if (commit_s) begin
                lo_r <= plo_r;
            end else if (mtlo_s) begin
                lo_r <= A;
            end else begin
                lo_r <= lo_r;
            end
        end
    end

    assign Busy = (state_r == RUN);
    assign HI   = hi_r;
    assign LO   = lo_r;
    assign Out  = out_s;

endmodule

// File: tb/tb_e_mdu.sv
// Randomised self-checking bench for e_mdu against a plain-arithmetic HI/LO model.
module tb_e_mdu;

    localparam int MULT_CYCLES = 5;
    localparam int DIV_CYCLES  = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  MDUOp = 4'd0;
    logic        Start = 1'b0;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic        Req = 1'b0;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] Out;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    e_mdu #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) dut (
        .clk(clk), .reset(reset), .MDUOp(MDUOp), .Start(Start), .A(A), .B(B),
        .Req(Req), .Busy(Busy), .HI(HI), .LO(LO), .Out(Out)
    );

    // Clock generator.
    always #5 clk = ~clk;

    // Protocol monitor: the upstream stall must keep Start/mthi/mtlo away while Busy.
    always @(posedge clk) begin
        if (reset && Busy) begin
            assert (!Start) else $error("protocol: Start while Busy");
            assert (!(MDUOp == 4'd7 || MDUOp == 4'd8)) else $error("protocol: mthi/mtlo while Busy");
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Architectural result of an op, derived from the ISA definitions.
    task automatic model_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            4'd1: begin p = 64'(sa * sb); m_hi = p[63:32]; m_lo = p[31:0]; end
            4'd2: begin p = {32'd0, a} * {32'd0, b}; m_hi = p[63:32]; m_lo = p[31:0]; end
            4'd3: if (b != 32'd0) begin
                      q = sa / sb; r = sa % sb;
                      m_lo = q[31:0]; m_hi = r[31:0];
                  end
            4'd4: if (b != 32'd0) begin m_lo = a / b; m_hi = a % b; end
            4'd7: m_hi = a;
            4'd8: m_lo = a;
            default: ;
        endcase
    endtask

    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic req, input logic midreq);
        int lat, n;
        logic [31:0] exp_out;
        @(negedge clk);
        MDUOp = op; A = a; B = b; Req = req;
        Start = (op >= 4'd1 && op <= 4'd4);
        #1;
        exp_out = (op == 4'd5) ? m_hi : (op == 4'd6) ? m_lo : 32'd0;
        check("out", {32'd0, Out}, {32'd0, exp_out});
        lat = 0;
        if (!req && (op == 4'd1 || op == 4'd2)) lat = MULT_CYCLES;
        if (!req && (op == 4'd3 || op == 4'd4)) lat = DIV_CYCLES;
        if (!req) model_op(op, a, b);
        @(negedge clk);
        Start = 1'b0; MDUOp = 4'd0; Req = 1'b0;
        A = $urandom; B = $urandom;
        n = 0;
        while (Busy && n < 64) begin
            n++;
            Req = midreq ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
        end
        Req = 1'b0;
        check("busy_len", 64'(n), 64'(lat));
        check("hi", {32'd0, HI}, {32'd0, m_hi});
        check("lo", {32'd0, LO}, {32'd0, m_lo});
    endtask

    function automatic logic [31:0] rand_val();
        case ($urandom_range(0, 7))
            0: return 32'h8000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'd0;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int n;
        #12;
        check("rst_busy", {63'd0, Busy}, 64'd0);
        check("rst_hi", {32'd0, HI}, 64'd0);
        check("rst_lo", {32'd0, LO}, 64'd0);
        reset = 1'b1;

        do_op(4'd1, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 1'b0);
        check("mult_hi", {32'd0, HI}, 64'h0000_0000_FFFF_FFFF);
        check("mult_lo", {32'd0, LO}, 64'h0000_0000_FFFF_FFFE);
        do_op(4'd6, 32'd0, 32'd0, 1'b0, 1'b0);
        do_op(4'd2, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 1'b0);
        check("multu_hi", {32'd0, HI}, 64'h1);
        do_op(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        check("div_lo", {32'd0, LO}, 64'h0000_0000_FFFF_FFFD);
        check("div_hi", {32'd0, HI}, 64'h0000_0000_FFFF_FFFF);
        do_op(4'd4, 32'd7, 32'd2, 1'b0, 1'b0);
        check("divu_lo", {32'd0, LO}, 64'd3);
        check("divu_hi", {32'd0, HI}, 64'd1);
        do_op(4'd3, 32'd100, 32'd0, 1'b0, 1'b0);
        check("divz_lo", {32'd0, LO}, 64'd3);
        do_op(4'd7, 32'h1234_5678, 32'd0, 1'b0, 1'b0);
        check("mthi", {32'd0, HI}, 64'h1234_5678);
        do_op(4'd7, 32'hDEAD_BEEF, 32'd0, 1'b1, 1'b0);
        check("mthi_req", {32'd0, HI}, 64'h1234_5678);
        do_op(4'd1, 32'd3, 32'd4, 1'b1, 1'b0);
        do_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1);
        check("ovf_lo", {32'd0, LO}, 64'h8000_0000);

        for (int i = 0; i < 60; i++) begin
            do_op(4'($urandom_range(1, 8)), rand_val(), rand_val(),
                  ($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)));
        end
        do_op(4'd5, 32'd0, 32'd0, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a divide.
        @(negedge clk);
        MDUOp = 4'd4; A = 32'd50; B = 32'd7; Start = 1'b1;
        @(negedge clk);
        MDUOp = 4'd0; Start = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("arst_busy", {63'd0, Busy}, 64'd0);
        check("arst_hi", {32'd0, HI}, 64'd0);
        check("arst_lo", {32'd0, LO}, 64'd0);
        m_hi = 32'd0; m_lo = 32'd0;
        @(negedge clk);
        reset = 1'b1;
        n = 0;
        repeat (15) begin
            @(negedge clk);
            if (Busy) n++;
        end
        check("arst_nobusy", 64'(n), 64'd0);
        check("arst_nocommit_hi", {32'd0, HI}, 64'd0);
        check("arst_nocommit_lo", {32'd0, LO}, 64'd0);
        do_op(4'd1, 32'd6, 32'd7, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
